// File: rtl/neuron_pkg.sv
// ============================================================================
//  neuron_pkg
//  Shared widths and scheduler state encoding for the LIF neuron layer.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package neuron_pkg;

  localparam int DFLT_N_STAGE = 2;
  localparam int IN_W         = 2**DFLT_N_STAGE;
  localparam int MEM_W        = DFLT_N_STAGE + 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/neuron.sv
// ============================================================================
//  neuron
//  Combinational LIF neuron: leak-or-reset, weighted spike count, saturate.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module neuron
  import neuron_pkg::*;
#(
  parameter int N_STAGE = DFLT_N_STAGE
) (
  input  logic [2**N_STAGE-1:0]      in_spikes,
  input  logic [2**N_STAGE-1:0]      weights,
  input  logic signed [N_STAGE+1:0]  last_membrane,
  input  logic                       was_spike,
  input  logic [2:0]                 shift,
  input  logic signed [N_STAGE+1:0]  threshold,
  output logic signed [N_STAGE+1:0]  new_membrane,
  output logic                       is_spike
);

  localparam int c_IN_W  = 2**N_STAGE;
  localparam int c_MEM_W = N_STAGE + 2;
  localparam int c_SUM_W = N_STAGE + 1;
  localparam logic signed [c_MEM_W:0] c_MAX = (c_MEM_W+1)'((1 << (c_MEM_W - 1)) - 1);

  logic [c_SUM_W-1:0]        w_sum;
  logic signed [c_MEM_W-1:0] w_leak;
  logic signed [c_MEM_W:0]   w_total;

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < c_IN_W; i++) begin
      w_sum = w_sum + c_SUM_W'(in_spikes[i] & weights[i]);
    end
    // A neuron that fired last timestep restarts from rest instead of leaking.
    w_leak  = was_spike ? '0 : (last_membrane >>> shift);
    w_total = $signed({w_leak[c_MEM_W-1], w_leak})
            + $signed({{(c_MEM_W + 1 - c_SUM_W){1'b0}}, w_sum});
    new_membrane = (w_total > c_MAX) ? c_MAX[c_MEM_W-1:0] : w_total[c_MEM_W-1:0];
    is_spike     = (new_membrane >= threshold);
  end

endmodule

`default_nettype wire

// File: rtl/neuron_layer_scheduler.sv
// ============================================================================
//  neuron_layer_scheduler
//  Steps one shared neuron across N_NEURONS per timestep, holding layer state.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module neuron_layer_scheduler
  import neuron_pkg::*;
#(
  parameter int N_STAGE   = DFLT_N_STAGE,
  parameter int N_NEURONS = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [2**N_STAGE-1:0]        in_spikes,
  input  logic                         cfg_we,
  input  logic [$clog2(N_NEURONS)-1:0] cfg_addr,
  input  logic [2**N_STAGE-1:0]        cfg_weights,
  input  logic [2:0]                   shift,
  input  logic [N_STAGE+1:0]           threshold,
  input  logic                         clear_state,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [N_NEURONS-1:0]         out_spikes,
  output logic                         busy
);

  localparam int c_IN_W  = 2**N_STAGE;
  localparam int c_MEM_W = N_STAGE + 2;
  localparam int c_IW    = $clog2(N_NEURONS);
  localparam logic [c_IW-1:0] c_LAST = c_IW'(N_NEURONS - 1);

  state_t                    r_state, w_next;
  logic [c_IW-1:0]           r_idx;
  logic [c_IN_W-1:0]         r_spk_in;
  logic [2:0]                r_shift;
  logic signed [c_MEM_W-1:0] r_thr;
  logic [c_IN_W-1:0]         r_w   [N_NEURONS];
  logic signed [c_MEM_W-1:0] r_mem [N_NEURONS];
  logic [N_NEURONS-1:0]      r_ws;
  logic [N_NEURONS-1:0]      r_out;
  logic                      r_old_vld;
  logic [c_IW-1:0]           r_old_addr;
  logic [c_IN_W-1:0]         r_old_w;

  logic                      w_addr_ok, w_accept, w_wr, w_spk;
  logic [c_IN_W-1:0]         w_wsel;
  logic signed [c_MEM_W-1:0] w_new;

  assign w_addr_ok = (32'(cfg_addr) < N_NEURONS);
  assign w_accept  = (r_state == IDLE) && in_valid;
  assign w_wr      = (r_state == IDLE) && cfg_we && w_addr_ok;
  // A write landing on the accept edge must not affect the timestep it races.
  assign w_wsel    = (r_old_vld && (r_old_addr == r_idx)) ? r_old_w : r_w[r_idx];
  assign out_spikes = r_out;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (r_idx == c_LAST) w_next = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx      <= '0;
      r_spk_in   <= '0;
      r_shift    <= '0;
      r_thr      <= '0;
      r_ws       <= '0;
      r_out      <= '0;
      r_old_vld  <= 1'b0;
      r_old_addr <= '0;
      r_old_w    <= '0;
      for (int i = 0; i < N_NEURONS; i++) begin
        r_w[i]   <= '0;
        r_mem[i] <= '0;
      end
    end else begin
      if (w_wr) r_w[cfg_addr] <= cfg_weights;
      if (w_accept) begin
        r_spk_in   <= in_spikes;
        r_shift    <= shift;
        r_thr      <= threshold;
        r_idx      <= '0;
        r_old_vld  <= w_wr;
        r_old_addr <= cfg_addr;
        r_old_w    <= r_w[cfg_addr];
      end
      if ((r_state == IDLE) && clear_state) begin
        r_ws <= '0;
        for (int i = 0; i < N_NEURONS; i++) r_mem[i] <= '0;
      end
      if (r_state == RUN) begin
        r_mem[r_idx] <= w_new;
        r_ws[r_idx]  <= w_spk;
        r_out[r_idx] <= w_spk;
        r_idx        <= r_idx + 1'b1;
      end
    end
  end

  neuron #(.N_STAGE(N_STAGE)) u_neuron (
    .in_spikes     (r_spk_in),
    .weights       (w_wsel),
    .last_membrane (r_mem[r_idx]),
    .was_spike     (r_ws[r_idx]),
    .shift         (r_shift),
    .threshold     (r_thr),
    .new_membrane  (w_new),
    .is_spike      (w_spk)
  );

endmodule

`default_nettype wire

// File: tb/tb_neuron_layer_scheduler.sv
// ============================================================================
//  tb_neuron_layer_scheduler
//  Directed bench with a timestep-level behavioural model of the layer.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_neuron_layer_scheduler;
  import neuron_pkg::*;

  localparam int N = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0, cfg_we = 1'b0, clear_state = 1'b0, out_ready = 1'b1;
  logic [IN_W-1:0]  in_spikes = '0, cfg_weights = '0;
  logic [1:0]       cfg_addr = '0;
  logic [2:0]       shift = '0;
  logic [MEM_W-1:0] threshold = '0;
  logic             in_ready, out_valid, busy;
  logic [N-1:0]     out_spikes;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  neuron_layer_scheduler #(.N_STAGE(DFLT_N_STAGE), .N_NEURONS(N)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_spikes(in_spikes), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_weights(cfg_weights), .shift(shift), .threshold(threshold),
    .clear_state(clear_state), .out_valid(out_valid), .out_ready(out_ready),
    .out_spikes(out_spikes), .busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, $signed(act), $signed(exp));
    end
  endtask

  // Model: phase -1 idle, 0..N-1 cycles into RUN, N = result presented.
  int             m_phase;
  int             m_mem [N];
  bit [N-1:0]     m_ws;
  logic [IN_W-1:0] m_w  [N];
  logic [N-1:0]   m_spk;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase = -1;
      m_ws    = '0;
      m_spk   = '0;
      for (int i = 0; i < N; i++) begin
        m_mem[i] = 0;
        m_w[i]   = '0;
      end
    end else if (m_phase == -1) begin
      if (clear_state) begin
        m_ws = '0;
        for (int i = 0; i < N; i++) m_mem[i] = 0;
      end
      if (in_valid) begin
        for (int i = 0; i < N; i++) begin
          int lk, nv;
          lk = m_ws[i] ? 0 : (m_mem[i] >>> shift);
          nv = lk + $countones(in_spikes & m_w[i]);
          if (nv > 7) nv = 7;
          m_mem[i] = nv;
          m_ws[i]  = (nv >= int'($signed(threshold)));
          m_spk[i] = m_ws[i];
        end
        m_phase = 0;
      end
      if (cfg_we && (int'(cfg_addr) < N)) m_w[cfg_addr] = cfg_weights;
    end else if (m_phase < N) begin
      m_phase++;
    end else if (out_ready) begin
      m_phase = -1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", 32'(in_ready), 32'(m_phase == -1));
      chk("busy", 32'(busy), 32'(m_phase >= 0));
      chk("out_valid", 32'(out_valid), 32'(m_phase == N));
      if (m_phase == N) chk("out_spikes", 32'(out_spikes), 32'(m_spk));
      if (m_phase == -1 || m_phase == N) begin
        for (int i = 0; i < N; i++) begin
          chk($sformatf("mem%0d", i), 32'($signed(dut.r_mem[i])), 32'(m_mem[i]));
          chk($sformatf("was_spike%0d", i), 32'(dut.r_ws[i]), 32'(m_ws[i]));
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] addr, input logic [3:0] wts);
    step();
    cfg_we = 1'b1; cfg_addr = addr; cfg_weights = wts;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic accept(input logic [3:0] sp, input logic [3:0] thr, input logic [2:0] sh,
                        input logic clr, input logic we, input logic [1:0] addr,
                        input logic [3:0] wts);
    step();
    in_spikes = sp; threshold = thr; shift = sh; clear_state = clr;
    cfg_we = we; cfg_addr = addr; cfg_weights = wts; in_valid = 1'b1;
    step();
    in_valid = 1'b0; clear_state = 1'b0; cfg_we = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (!out_valid) begin
      errors++;
      $display("FAIL done_timeout actual=%0d required=%0d", n, N);
    end else if (n != N) begin
      errors++;
      $display("FAIL latency actual=%0d required=%0d", n, N);
    end
  endtask

  task automatic run_ts(input logic [3:0] sp, input logic [3:0] thr, input logic [2:0] sh,
                        input logic clr, input logic [3:0] exp_spk);
    accept(sp, thr, sh, clr, 1'b0, 2'd0, 4'd0);
    wait_done();
    chk("ts_spikes", 32'(out_spikes), 32'(exp_spk));
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) step();
    reset = 1'b0;
    chk_en = 1'b1;
    step();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_spikes", 32'(out_spikes), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    run_ts(4'b1111, 4'd7, 3'd0, 1'b0, 4'b0000);
    run_ts(4'b1111, 4'd0, 3'd0, 1'b0, 4'b1111);
    run_ts(4'b1111, 4'd0, 3'd0, 1'b0, 4'b1111);

    cfg_write(2'd0, 4'b1111);
    cfg_write(2'd1, 4'b0000);
    cfg_write(2'd2, 4'b1111);
    cfg_write(2'd3, 4'b0000);
    for (int t = 0; t < 3; t++) run_ts(4'b1111, 4'd2, 3'd0, 1'b0, 4'b0101);
    chk("model_mem0", 32'(m_mem[0]), 32'd4);
    chk("dut_mem0", 32'($signed(dut.r_mem[0])), 32'd4);

    // Backpressure while a write to neuron 1 is attempted.
    out_ready = 1'b0;
    accept(4'b1111, 4'd2, 3'd0, 1'b0, 1'b0, 2'd0, 4'd0);
    wait_done();
    cfg_we = 1'b1; cfg_addr = 2'd1; cfg_weights = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("bp_hold_spikes", 32'(out_spikes), 32'b0101);
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
    end
    cfg_we = 1'b0;
    out_ready = 1'b1;
    step();
    run_ts(4'b1111, 4'd2, 3'd0, 1'b0, 4'b0101);

    // Write on the accept edge: old weights now, new weights next timestep.
    accept(4'b1111, 4'd2, 3'd0, 1'b0, 1'b1, 2'd1, 4'b1111);
    wait_done();
    chk("race_old_w", 32'(out_spikes), 32'b0101);
    step();
    run_ts(4'b1111, 4'd2, 3'd0, 1'b0, 4'b0111);

    // Reset at RUN idx 2.
    accept(4'b1111, 4'd2, 3'd0, 1'b0, 1'b0, 2'd0, 4'd0);
    step();
    step();
    chk("mid_run_idx", 32'(dut.r_idx), 32'd2);
    reset = 1'b1;
    step();
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    step();

    cfg_write(2'd0, 4'b0001);
    run_ts(4'b0001, 4'd7, 3'd0, 1'b0, 4'b0000);
    run_ts(4'b0001, 4'd7, 3'd0, 1'b0, 4'b0000);
    run_ts(4'b0001, 4'd7, 3'd1, 1'b0, 4'b0000);
    chk("shift_mem0", 32'($signed(dut.r_mem[0])), 32'd2);
    run_ts(4'b0001, 4'd7, 3'd0, 1'b1, 4'b0000);
    chk("clear_mem0", 32'($signed(dut.r_mem[0])), 32'd1);
    chk("clear_model_mem0", 32'(m_mem[0]), 32'd1);

    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
